// File: rtl/hex_ascii_pkg.sv
// rtl/hex_ascii_pkg.sv - shared FSM states, ASCII constants and nibble-to-ASCII encoder
// Build option: HEX_ASCII_CRLF_EN adds the CR and LF terminator states.
package hex_ascii_pkg;

`ifdef HEX_ASCII_CRLF_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        CR    = 2'd2,
        LF    = 2'd3
    } state_e;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DIGIT = 1'b1
    } state_e;
`endif

    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    localparam logic [7:0] ASCII_UPPER_OFS  = 8'h37;
    localparam logic [7:0] ASCII_LOWER_OFS  = 8'h57;
    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;

    // Offsets are chosen so that base + nibble lands on '0'..'9', 'A'..'F' or 'a'..'f'.
    function automatic logic [7:0] nib2ascii(input logic [3:0] nibble, input logic lower);
        logic [7:0] n8;
        n8 = {4'h0, nibble};
        if (nibble < 4'd10) begin
            return ASCII_DIGIT_BASE + n8;
        end
        return (lower ? ASCII_LOWER_OFS : ASCII_UPPER_OFS) + n8;
    endfunction

endpackage

// File: rtl/hex_lzc.sv
// rtl/hex_lzc.sv - combinational leading-zero hex digit counter
// Ports: data (4*NIBBLES word in), lz (count of leading zero nibbles, NIBBLES when all zero).
module hex_lzc #(
    parameter int NIBBLES = 4
) (
    input  logic [4*NIBBLES-1:0]         data,
    output logic [$clog2(NIBBLES+1)-1:0] lz
);

    localparam int CW = $clog2(NIBBLES + 1);

    // Ascending scan: the last non-zero nibble seen is the most significant one.
    always_comb begin
        lz = CW'(NIBBLES);
        for (int i = 0; i < NIBBLES; i++) begin
            if (data[4*i +: 4] != 4'h0) begin
                lz = CW'(NIBBLES - 1 - i);
            end
        end
    end

endmodule

// File: rtl/hex_ascii_streamer.sv
// rtl/hex_ascii_streamer.sv - serialises an N-nibble word as ASCII hex characters, MS digit first
// Ports: clk, rst (async active-low); in_valid/in_ready/in_data/in_lower word input;
//        out_valid/out_ready/out_data/out_last character output; busy while a word is emitted.
// Build option: HEX_ASCII_CRLF_EN appends CR, LF to every word and moves out_last to LF.
module hex_ascii_streamer
    import hex_ascii_pkg::*;
#(
    parameter int NIBBLES        = 4,
    parameter int SUPPRESS_ZEROS = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_data,
    input  logic                 in_lower,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NIBBLES - 1);
`ifdef HEX_ASCII_CRLF_EN
    localparam logic DIGIT_LAST = 1'b0;
`else
    localparam logic DIGIT_LAST = 1'b1;
`endif

    state_e        state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lower_q, lower_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_last_q, out_last_d;

    logic [CW-1:0] lz_raw, lz, cnt_inc;
    logic [W-1:0]  in_shifted, shreg_nxt;

    generate
        if (SUPPRESS_ZEROS != 0) begin : g_lzc
            hex_lzc #(.NIBBLES(NIBBLES)) u_lzc (
                .data (in_data),
                .lz   (lz_raw)
            );
        end else begin : g_no_lzc
            assign lz_raw = '0;
        end
    endgenerate

    // An all-zero word still sends its final '0'.
    assign lz         = (lz_raw > LAST_IDX) ? LAST_IDX : lz_raw;
    assign in_shifted = in_data << {lz, 2'b00};
    assign shreg_nxt  = shreg_q << 4;
    assign cnt_inc    = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        lower_d     = lower_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d     = DIGIT;
                    shreg_d     = in_shifted;
                    cnt_d       = lz;
                    lower_d     = in_lower;
                    out_valid_d = 1'b1;
                    out_data_d  = nib2ascii(in_shifted[W-1 -: 4], in_lower);
                    out_last_d  = DIGIT_LAST && (lz == LAST_IDX);
                end
            end
            DIGIT: begin
                if (out_ready) begin
                    if (cnt_q == LAST_IDX) begin
`ifdef HEX_ASCII_CRLF_EN
                        state_d     = CR;
                        out_data_d  = ASCII_CR;
                        out_last_d  = 1'b0;
`else
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
`endif
                    end else begin
                        shreg_d    = shreg_nxt;
                        cnt_d      = cnt_inc;
                        out_data_d = nib2ascii(shreg_nxt[W-1 -: 4], lower_q);
                        out_last_d = DIGIT_LAST && (cnt_inc == LAST_IDX);
                    end
                end
            end
`ifdef HEX_ASCII_CRLF_EN
            CR: begin
                if (out_ready) begin
                    state_d    = LF;
                    out_data_d = ASCII_LF;
                    out_last_d = 1'b1;
                end
            end
            LF: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            lower_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            lower_q     <= lower_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_hex_ascii_streamer.sv
// tb/tb_hex_ascii_streamer.sv - self-checking bench for hex_ascii_streamer (NIBBLES=4, SUPPRESS_ZEROS=1)
module tb_hex_ascii_streamer;

    localparam int N  = 4;
    localparam int SZ = 1;
`ifdef HEX_ASCII_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif
    localparam logic DL = !CRLF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        in_lower = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    int tests = 0;
    int fails = 0;
    bit rdy_rand = 1'b0;

    logic [8:0] exp_q[$];
    logic [8:0] log_q[$];
    logic [8:0] lit_q[$];

    hex_ascii_streamer #(.NIBBLES(N), .SUPPRESS_ZEROS(SZ)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_lower  (in_lower),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexch(input int d, input logic lower);
        if (d < 10) return 8'(48 + d);
        return 8'((lower ? 97 : 65) + d - 10);
    endfunction

    // Reference model: the character string a word must produce.
    task automatic model_push(input logic [15:0] w, input logic lower);
        int first;
        int d;
        first = 0;
        if (SZ != 0) begin
            while (first < N - 1 && ((int'(w) >> (4 * (N - 1 - first))) & 15) == 0) first++;
        end
        for (int i = first; i < N; i++) begin
            d = (int'(w) >> (4 * (N - 1 - i))) & 15;
            exp_q.push_back({(!CRLF && i == N - 1) ? 1'b1 : 1'b0, hexch(d, lower)});
        end
        if (CRLF) begin
            exp_q.push_back({1'b0, 8'd13});
            exp_q.push_back({1'b1, 8'd10});
        end
    endtask

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("in_ready", in_ready, exp_q.size() == 0);
            chk("busy", busy, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                chk("out_data", out_data, exp_q[0][7:0]);
                chk("out_last", out_last, exp_q[0][8]);
                if (out_ready) begin
                    log_q.push_back({out_last, out_data});
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) model_push(in_data, in_lower);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [15:0] w, input logic lo);
        logic hs;
        hs = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        in_lower = lo;
        for (int n = 0; n < 200 && !hs; n++) begin
            hs = in_ready;
            step();
        end
        if (!hs) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            if (toggle) in_lower = ~in_lower;
            step();
            n++;
        end
        if (n >= 400) chk("drain_timeout", 0, 1);
    endtask

    task automatic lit(input logic [7:0] c, input logic l);
        lit_q.push_back({l, c});
    endtask

    task automatic lit_end();
        if (CRLF) begin
            lit(8'h0D, 1'b0);
            lit(8'h0A, 1'b1);
        end
    endtask

    task automatic cmp_log(input string name);
        chk({name, "_len"}, log_q.size(), lit_q.size());
        for (int i = 0; i < lit_q.size() && i < log_q.size(); i++) chk(name, log_q[i], lit_q[i]);
        log_q.delete();
        lit_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);

        send(16'h1A3F, 1'b0);
        drain(1'b0);
        lit(8'h31, 0); lit(8'h41, 0); lit(8'h33, 0); lit(8'h46, DL); lit_end();
        cmp_log("w1A3F");

        send(16'hBEEF, 1'b1);
        drain(1'b1);
        lit(8'h62, 0); lit(8'h65, 0); lit(8'h65, 0); lit(8'h66, DL); lit_end();
        cmp_log("wBEEF");

        send(16'h00C0, 1'b0);
        drain(1'b0);
        lit(8'h43, 0); lit(8'h30, DL); lit_end();
        cmp_log("w00C0");

        send(16'h0000, 1'b0);
        drain(1'b0);
        lit(8'h30, DL); lit_end();
        cmp_log("w0000");

        send(16'h8000, 1'b0);
        drain(1'b0);
        lit(8'h38, 0); lit(8'h30, 0); lit(8'h30, 0); lit(8'h30, DL); lit_end();
        cmp_log("w8000");

        send(16'h00FF, 1'b0);
        send(16'h0007, 1'b1);
        drain(1'b0);
        lit(8'h46, 0); lit(8'h46, DL); lit_end();
        lit(8'h37, DL); lit_end();
        cmp_log("w00FF_b2b");

        // Backpressure on the second character
        send(16'h1234, 1'b0);
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_data", out_data, 8'h32);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        drain(1'b0);
        lit(8'h31, 0); lit(8'h32, 0); lit(8'h33, 0); lit(8'h34, DL); lit_end();
        cmp_log("w1234_stall");

        // Asynchronous reset during the third character
        send(16'h1234, 1'b0);
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 8'h00);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        step();
        rst = 1'b1;
        log_q.delete();
        step();
        send(16'hABCD, 1'b1);
        drain(1'b0);
        lit(8'h61, 0); lit(8'h62, 0); lit(8'h63, 0); lit(8'h64, DL); lit_end();
        cmp_log("wABCD_after_rst");

        // Randomised traffic with random backpressure
        rdy_rand = 1'b1;
        for (int k = 0; k < 300; k++) begin
            for (int j = 0; j < 4; j++) begin
                w[4*j +: 4] = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            send(w, 1'($urandom_range(0, 1)));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                in_lower = 1'($urandom_range(0, 1));
                step();
            end
        end
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        drain(1'b0);
        log_q.delete();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_ascii_streamer.md
# hex_ascii_streamer

Parametrised hex-to-ASCII serializer. Accepts an N-nibble word on a valid/ready input and emits its hexadecimal representation as a byte stream on a valid/ready output, one ASCII character per accepted transfer, MS nibble first. It supports upper/lower-case letters, optional leading-zero suppression, and an optional CR/LF terminator. It feeds the UART/console TX path and replaces the fixed four-byte parallel hex converter wherever characters must be sent serially.

## Interface
- NIBBLES, 4: digits per word (1..16); input width 4*NIBBLES.
- SUPPRESS_ZEROS, 0: 1 = skip leading zero digits. At least one digit is always sent.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  4*NIBBLES  word to convert.
- in_lower  in  1  sampled with the word: 1 = 'a'..'f', 0 = 'A'..'F'.
- out_valid  out  1  out_data holds a character.
- out_ready  in  1  downstream accepts a character.
- out_data  out  8  ASCII character.
- out_last  out  1  marks the final character of the word.
- busy  out  1  a word is being emitted (state != IDLE).

## Operation
- States: IDLE, DIGIT, plus CR and LF when HEX_ASCII_CRLF_EN is defined.
- IDLE: in_ready=1, out_valid=0. An in_valid&&in_ready handshake does the following:
  - Latches in_data into a shift register and latches in_lower.
  - Computes lz, the leading-zero digit count. lz=0 if SUPPRESS_ZEROS=0; otherwise lz=min(lz, NIBBLES-1).
  - Pre-shifts the register left by 4*lz and sets digit count cnt=lz.
  - Loads out_data with the first character, sets out_valid=1, and moves to DIGIT.
- DIGIT: out_data = ascii(top nibble).
  - On out_valid&&out_ready, if cnt==NIBBLES-1, the digit phase is done. Otherwise shift left 4, cnt++, and load the next character.
  - When the digit phase is done, go to IDLE, or to CR if CRLF is enabled.
- CR: out_data=8'h0D. On handshake, go to LF.
- LF: out_data=8'h0A, out_last=1. On handshake, go to IDLE.
- Conversion rules:
  - n<10 → 8'h30+n.
  - Upper case → 8'h37+n (0x41 for n=10).
  - Lower case → 8'h57+n (0x61 for n=10).
  - All arithmetic is 8-bit unsigned with no overflow possible.
- out_last=1 only on the final character: the last digit when CRLF is disabled, LF when it is enabled.
- in_ready=0 in every state except IDLE. A word offered while busy is held off, never dropped.

## Timing
- Reset values: out_valid=0, out_data=8'h00, out_last=0, busy=0, state=IDLE, in_ready=1 once reset is released.
- out_data, out_valid and out_last are registered. in_ready and busy decode from the state register.
- Latency: word accepted at edge k → first character valid after edge k (visible in cycle k+1).
- Throughput, with out_ready held high: one character per cycle. A word occupies NIBBLES−lz (+2 with CRLF) cycles, plus one IDLE cycle before the next word is accepted.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_last hold stable and no state advances.
- out_valid never deasserts without a handshake.
- An asynchronous reset in any state aborts the word immediately. Outputs return to their reset values and no partial-word completion is produced.
- in_lower changing mid-word has no effect; only the value latched at acceptance is used.

## Configuration
- HEX_ASCII_CRLF_EN, defined: every word is terminated with 8'h0D then 8'h0A, and out_last moves to LF.
- HEX_ASCII_CRLF_EN, undefined: CR/LF states and logic are absent, and the last digit carries out_last.

## Structure
- Package hex_ascii_pkg holds:
  - the state enum;
  - ASCII_DIGIT_BASE=8'h30, ASCII_UPPER_OFS=8'h37, ASCII_LOWER_OFS=8'h57, ASCII_CR=8'h0D, ASCII_LF=8'h0A;
  - function nib2ascii(nibble, lower).
- Sub-module hex_lzc (parameter NIBBLES): combinational leading-zero-digit counter, output width $clog2(NIBBLES+1). It is instantiated only when SUPPRESS_ZEROS=1; otherwise lz is tied to 0.

## Test plan
- NIBBLES=4, in_data=16'h1A3F, in_lower=0, out_ready=1 → bytes 31,41,33,46 on consecutive cycles, out_last only on 46.
- in_data=16'hBEEF, in_lower=1 → 62,65,65,66. Toggling in_lower mid-word does not change the output.
- SUPPRESS_ZEROS=1: 16'h00C0 → 43,30. 16'h0000 → single 30 with out_last. 16'h8000 → 38,30,30,30.
- out_ready driven low for 3 cycles on the second character of 16'h1234 → out_data stays 32 and out_valid stays 1. The sequence resumes with 33,34, and in_ready stays 0 throughout.
- HEX_ASCII_CRLF_EN with 16'h00FF → 30,30,46,46,0D,0A, out_last only on 0A. The next word is accepted one cycle after 0A.
- rst pulsed low during the third character → out_valid=0 and state IDLE immediately. The next word starts cleanly from its first digit.
